// File: rtl/ram_image_loader_pkg.sv
// Shared types and constants for the RAM image loader.
// Covers the FSM state encoding and the stream framing sizes.
package ram_image_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_BYTES,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_LEN        = 2;
endpackage

// File: rtl/ram_image_loader_packer.sv
// Assembles little-endian bytes into one RAM word; byte k lands in bits [8k+7:8k].
// word_ready flags the byte that completes the current word.
module ram_image_loader_packer
  import ram_image_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_in,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_ready
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;

  assign word_ready = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (byte_valid) begin
      word[8*lane +: 8] <= byte_in;
      lane              <= lane + LANE_W'(1);
    end
  end
endmodule

// File: rtl/ram_image_loader.sv
// Loads a length-prefixed byte image into the single-port RAM and verifies its checksum.
// Handshake: a byte moves when in_valid & in_ready are both high at a rising clk edge.
module ram_image_loader
  import ram_image_loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);
  localparam logic [63:0] LIMIT = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  state_t                 state;
  logic [8*HDR_LEN-1:0]   len;
  logic [8*HDR_LEN-1:0]   len_full;
  logic [7:0]             checksum;
  logic                   xfer;
  logic                   word_ready;
  logic                   pack_clear;

  assign in_ready   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_BYTES)  || (state == S_CHECK);
  assign xfer       = in_valid && in_ready;
  assign len_full   = {in_data, len[7:0]};
  assign pack_clear = (state == S_IDLE) && start;

  // Word register stays frozen during WRITE because no byte is accepted there.
  ram_image_loader_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .byte_valid (xfer && (state == S_BYTES)),
    .byte_in    (in_data),
    .word       (ram_data),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len           <= '0;
      checksum      <= '0;
      ram_address   <= ADDR_W'(BASE_ADDR);
      ram_wren      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      ram_wren <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            checksum      <= '0;
            ram_address   <= ADDR_W'(BASE_ADDR);
            busy          <= 1'b1;
            state         <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= in_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len <= len_full;
            if (64'(len_full) > LIMIT) begin
              error <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (len_full == '0) begin
              state <= S_CHECK;
            end else begin
              state <= S_BYTES;
            end
          end
        end
        S_BYTES: begin
          if (xfer) begin
            checksum <= checksum + in_data;
            if (word_ready) begin
              ram_wren <= 1'b1;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          ram_address   <= ram_address + ADDR_W'(1);
          words_written <= words_written + (ADDR_W + 1)'(1);
          state         <= (32'(words_written) + 32'd1 == 32'(len)) ? S_CHECK : S_BYTES;
        end
        S_CHECK: begin
          if (xfer) begin
            error <= (in_data != checksum);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_image_loader.sv
// Self-checking bench for ram_image_loader: scoreboard of expected RAM writes
// plus per-scenario tasks for reset, checksum, empty image, gaps and oversize.
module tb_ram_image_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        busy, done, error;
  logic [16:0] words_written;

  logic        s_start = 1'b0;
  logic        s_in_valid = 1'b0;
  logic [7:0]  s_in_data = 8'h00;
  logic        s_in_ready;
  logic [3:0]  s_ram_address;
  logic [31:0] s_ram_data;
  logic        s_ram_wren;
  logic        s_busy, s_done, s_error;
  logic [4:0]  s_words_written;

  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;
  int          s_wr_count = 0;
  bit          gaps = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_exp;
  logic [31:0] ram_m [0:255];

  always #5 clk = ~clk;

  ram_image_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  ram_image_loader #(.ADDR_W(4), .DATA_W(32), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .ram_address(s_ram_address), .ram_data(s_ram_data),
    .ram_wren(s_ram_wren), .busy(s_busy), .done(s_done), .error(s_error),
    .words_written(s_words_written)
  );

  // Behavioural single-port RAM: write on clk edge, read back by index.
  always @(posedge clk) if (ram_wren) ram_m[ram_address[7:0]] <= ram_data;

  always @(negedge clk) begin
    if (rst_n && ram_wren) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", ram_address, ram_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({ram_address, ram_data} !== mon_exp) begin
          errors++;
          $display("FAIL write_word: got addr=%h data=%h, expected addr=%h data=%h",
                   ram_address, ram_data, mon_exp[47:32], mon_exp[31:0]);
        end
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL write_cycle_flags: got in_ready=%b busy=%b, expected in_ready=0 busy=1", in_ready, busy);
      end
    end
    if (s_ram_wren) s_wr_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    if (gaps) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after 50 cycles, expected 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    @(negedge clk);
    while (done !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%b after 50 cycles, expected 1", done);
    end
  endtask

  task automatic run_load(input int n, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [7:0] chk);
    logic [31:0] w;
    start_pulse();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      exp_q.push_back({16'(i), w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    send_byte(chk);
    wait_done();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ram_wren, busy, done, error, in_ready} !== 5'b0 || words_written !== 17'd0 ||
        ram_address !== 16'd0 || ram_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: wren=%b busy=%b done=%b err=%b rdy=%b ww=%0d addr=%h data=%h, expected all 0",
               ram_wren, busy, done, error, in_ready, words_written, ram_address, ram_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_ready: got %b, expected 0", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_normal();
    ram_m[0] = 32'd0; ram_m[1] = 32'd0;
    wr_count = 0;
    run_load(2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h4C);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || words_written !== 17'd2) begin
      errors++;
      $display("FAIL normal_flags: done=%b err=%b busy=%b ww=%0d, expected 1 0 0 2", done, error, busy, words_written);
    end
    checks++;
    if (ram_m[0] !== 32'h1234_5678 || ram_m[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL normal_readback: got %h %h, expected 12345678 deadbeef", ram_m[0], ram_m[1]);
    end
    checks++;
    if (wr_count != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL normal_writes: got %0d writes, %0d pending, expected 2 and 0", wr_count, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL normal_hold: done=%b err=%b, expected 1 0", done, error);
    end
  endtask

  task automatic test_bad_checksum();
    wr_count = 0;
    run_load(2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h4D);
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || wr_count != 2) begin
      errors++;
      $display("FAIL bad_checksum: done=%b err=%b writes=%0d, expected 1 1 2", done, error, wr_count);
    end
  endtask

  task automatic test_empty();
    wr_count = 0;
    run_load(0, 32'd0, 32'd0, 8'h00);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || words_written !== 17'd0 || wr_count != 0) begin
      errors++;
      $display("FAIL empty_image: done=%b err=%b ww=%0d writes=%0d, expected 1 0 0 0",
               done, error, words_written, wr_count);
    end
  endtask

  task automatic test_gaps();
    ram_m[0] = 32'd0; ram_m[1] = 32'd0;
    wr_count = 0;
    gaps = 1'b1;
    run_load(2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h4C);
    gaps = 1'b0;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || words_written !== 17'd2 || wr_count != 2) begin
      errors++;
      $display("FAIL gaps_flags: done=%b err=%b ww=%0d writes=%0d, expected 1 0 2 2",
               done, error, words_written, wr_count);
    end
    checks++;
    if (ram_m[0] !== 32'h1234_5678 || ram_m[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL gaps_readback: got %h %h, expected 12345678 deadbeef", ram_m[0], ram_m[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    ram_m[0] = 32'd0; ram_m[1] = 32'd0;
    start_pulse();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_wren, busy, done, error, in_ready} !== 5'b0 || words_written !== 17'd0 ||
        ram_address !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: wren=%b busy=%b done=%b err=%b rdy=%b ww=%0d addr=%h, expected all 0",
               ram_wren, busy, done, error, in_ready, words_written, ram_address);
    end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    wr_count = 0;
    run_load(2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h4C);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wr_count != 2 ||
        ram_m[0] !== 32'h1234_5678 || ram_m[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL after_reset_load: done=%b err=%b writes=%0d ram=%h %h, expected 1 0 2 12345678 deadbeef",
               done, error, wr_count, ram_m[0], ram_m[1]);
    end
  endtask

  task automatic test_oversize();
    logic [7:0] hdr [2];
    int         budget;
    int         busy_rdy;
    hdr[0] = 8'h11;
    hdr[1] = 8'h00;
    s_wr_count = 0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = hdr[i];
      budget = 0;
      @(negedge clk);
      while (s_in_ready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 50) begin
        checks++; errors++;
        $display("FAIL oversize_send_timeout: in_ready=%b, expected 1", s_in_ready);
      end
      @(posedge clk); #1;
    end
    s_in_data = 8'hAA;
    busy_rdy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (s_in_ready !== 1'b0) busy_rdy++;
    end
    s_in_valid = 1'b0;
    checks++;
    if (busy_rdy != 0) begin
      errors++;
      $display("FAIL oversize_in_ready: in_ready high on %0d cycles, expected 0", busy_rdy);
    end
    checks++;
    if (s_done !== 1'b1 || s_error !== 1'b1 || s_busy !== 1'b0 ||
        s_words_written !== 5'd0 || s_wr_count != 0) begin
      errors++;
      $display("FAIL oversize_flags: done=%b err=%b busy=%b ww=%0d writes=%0d, expected 1 1 0 0 0",
               s_done, s_error, s_busy, s_words_written, s_wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_checksum();
    test_empty();
    test_gaps();
    test_reset_mid_load();
    test_oversize();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d writes pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
